// File: rtl/fifo_mxn_cfg.sv
// Parametrised synchronous FIFO with fill level, thresholds and sticky error flags.
// Strobes are edge- or level-sensitive; the read port can be registered or fall-through.
module fifo_mxn_cfg #(
  parameter int DW     = 8,
  parameter int AW     = 4,
  parameter int EDGE   = 1,
  parameter int FWFT   = 0,
  parameter int AF_LVL = (1 << AW) - 2,
  parameter int AE_LVL = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ien,
  input  logic          oen,
  input  logic [DW-1:0] idat,
  input  logic          clr_err,
  output logic [DW-1:0] odat,
  output logic          full,
  output logic          empty,
  output logic          afull,
  output logic          aempty,
  output logic [AW:0]   level,
  output logic          ovf,
  output logic          udf
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [AW:0] AF_L    = (AW+1)'(AF_LVL);
  localparam logic [AW:0] AE_L    = (AW+1)'(AE_LVL);

  logic [DW-1:0] mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   lvl_q, lvl_d;
  logic [DW-1:0] odat_q, odat_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;
  logic          ien_q, oen_q;
  logic          push, pop, push_ok, pop_ok;

  assign empty  = (lvl_q == '0);
  assign full   = (lvl_q == DEPTH_L);
  assign afull  = (lvl_q >= AF_L);
  assign aempty = (lvl_q <= AE_L);
  assign level  = lvl_q;
  assign ovf    = ovf_q;
  assign udf    = udf_q;

  // Fall-through mode shows the head word directly; registered mode holds the last pop.
  assign odat = (FWFT != 0) ? (empty ? '0 : mem_q[rp_q]) : odat_q;

  always_comb begin
    push    = (EDGE != 0) ? (ien_q & ~ien) : ien;
    pop     = (EDGE != 0) ? (oen_q & ~oen) : oen;
    pop_ok  = pop & ~empty;
    push_ok = push & (~full | pop_ok);
  end

  always_comb begin
    wp_d   = wp_q;
    rp_d   = rp_q;
    lvl_d  = lvl_q;
    odat_d = odat_q;
    if (push_ok) wp_d = wp_q + 1'b1;
    if (pop_ok) begin
      rp_d   = rp_q + 1'b1;
      odat_d = mem_q[rp_q];
    end
    case ({push_ok, pop_ok})
      2'b10:   lvl_d = lvl_q + 1'b1;
      2'b01:   lvl_d = lvl_q - 1'b1;
      default: lvl_d = lvl_q;
    endcase
  end

  // A fresh error in the same cycle as clr_err keeps the flag set.
  always_comb begin
    ovf_d = ovf_q;
    udf_d = udf_q;
    if (clr_err) begin
      ovf_d = 1'b0;
      udf_d = 1'b0;
    end
    if (push & ~push_ok) ovf_d = 1'b1;
    if (pop & ~pop_ok)   udf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst && push_ok) mem_q[wp_q] <= idat;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wp_q   <= '0;
      rp_q   <= '0;
      lvl_q  <= '0;
      odat_q <= '0;
      ovf_q  <= 1'b0;
      udf_q  <= 1'b0;
      ien_q  <= 1'b0;
      oen_q  <= 1'b0;
    end else begin
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      lvl_q  <= lvl_d;
      odat_q <= odat_d;
      ovf_q  <= ovf_d;
      udf_q  <= udf_d;
      ien_q  <= ien;
      oen_q  <= oen;
    end
  end

endmodule

// File: tb/tb_fifo_mxn_cfg.sv
// Directed bench for fifo_mxn_cfg: level-strobe, edge-strobe and fall-through instances.
// Expected read data comes from a scoreboard queue filled as pushes are driven.
module tb_fifo_mxn_cfg;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic       i0 = 0, o0 = 0, c0 = 0;
  logic [7:0] d0 = 0;
  logic [7:0] od0;
  logic       f0, e0, af0, ae0, ov0, ud0;
  logic [4:0] lv0;

  logic       i1 = 0, o1 = 0, c1 = 0;
  logic [7:0] d1 = 0;
  logic [7:0] od1;
  logic       f1, e1, af1, ae1, ov1, ud1;
  logic [4:0] lv1;

  logic       i2 = 0, o2 = 0, c2 = 0;
  logic [7:0] d2 = 0;
  logic [7:0] od2;
  logic       f2, e2, af2, ae2, ov2, ud2;
  logic [4:0] lv2;

  fifo_mxn_cfg #(.DW(8), .AW(4), .EDGE(0), .FWFT(0)) u0 (
    .clk(clk), .rst(rst), .ien(i0), .oen(o0), .idat(d0), .clr_err(c0),
    .odat(od0), .full(f0), .empty(e0), .afull(af0), .aempty(ae0),
    .level(lv0), .ovf(ov0), .udf(ud0));

  fifo_mxn_cfg #(.DW(8), .AW(4), .EDGE(1), .FWFT(0)) u1 (
    .clk(clk), .rst(rst), .ien(i1), .oen(o1), .idat(d1), .clr_err(c1),
    .odat(od1), .full(f1), .empty(e1), .afull(af1), .aempty(ae1),
    .level(lv1), .ovf(ov1), .udf(ud1));

  fifo_mxn_cfg #(.DW(8), .AW(4), .EDGE(0), .FWFT(1)) u2 (
    .clk(clk), .rst(rst), .ien(i2), .oen(o2), .idat(d2), .clr_err(c2),
    .odat(od2), .full(f2), .empty(e2), .afull(af2), .aempty(ae2),
    .level(lv2), .ovf(ov2), .udf(ud2));

  int tests = 0;
  int fails = 0;
  logic [7:0] sb[$];
  logic [7:0] exp_d;
  int lvl;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    tick();
    rst = 1;
    tick();

    // reset with FIFO half full and odat non-zero
    i0 = 1;
    for (int k = 0; k < 8; k++) begin
      d0 = 8'h10 + 8'(k);
      tick();
    end
    i0 = 0;
    o0 = 1;
    tick();
    tick();
    o0 = 0;
    chk("pre_rst_odat", od0, 8'h11);
    chk("pre_rst_lvl", lv0, 6);
    rst = 0;
    tick();
    rst = 1;
    chk("rst_lvl", lv0, 0);
    chk("rst_empty", e0, 1);
    chk("rst_full", f0, 0);
    chk("rst_odat", od0, 0);
    chk("rst_ovf", ov0, 0);
    chk("rst_udf", ud0, 0);

    // fill 0x00..0x0F
    i0 = 1;
    for (int k = 0; k < 16; k++) begin
      d0 = 8'(k);
      sb.push_back(d0);
      tick();
      chk("fill_lvl", lv0, k + 1);
      chk("fill_afull", af0, (k + 1 >= 14));
      chk("fill_full", f0, (k + 1 == 16));
    end
    d0 = 8'hEE;
    tick();
    i0 = 0;
    chk("ovf_set", ov0, 1);
    chk("ovf_lvl", lv0, 16);
    c0 = 1;
    tick();
    c0 = 0;
    chk("ovf_clr", ov0, 0);

    // drain with registered read
    o0 = 1;
    for (int k = 0; k < 16; k++) begin
      tick();
      exp_d = sb.pop_front();
      chk("drain_odat", od0, exp_d);
      chk("drain_lvl", lv0, 15 - k);
      chk("drain_aempty", ae0, (15 - k <= 2));
    end
    tick();
    o0 = 0;
    chk("udf_set", ud0, 1);
    chk("udf_odat_hold", od0, 8'h0F);
    chk("udf_empty", e0, 1);
    c0 = 1;
    tick();
    c0 = 0;
    chk("udf_clr", ud0, 0);

    // simultaneous push+pop at full
    i0 = 1;
    for (int k = 0; k < 16; k++) begin
      d0 = 8'h40 + 8'(k);
      sb.push_back(d0);
      tick();
    end
    chk("refill_full", f0, 1);
    o0 = 1;
    d0 = 8'hA5;
    sb.push_back(d0);
    tick();
    i0 = 0;
    exp_d = sb.pop_front();
    chk("full_pp_odat", od0, exp_d);
    chk("full_pp_lvl", lv0, 16);
    chk("full_pp_full", f0, 1);
    chk("full_pp_ovf", ov0, 0);
    for (int k = 0; k < 16; k++) begin
      tick();
      exp_d = sb.pop_front();
      chk("full_pp_drain", od0, exp_d);
    end
    o0 = 0;
    chk("full_pp_empty", e0, 1);
    chk("full_pp_udf", ud0, 0);

    // simultaneous push+pop at empty
    i0 = 1;
    o0 = 1;
    d0 = 8'h77;
    sb.push_back(d0);
    tick();
    chk("empty_pp_lvl", lv0, 1);
    chk("empty_pp_udf", ud0, 1);
    chk("empty_pp_odat", od0, 8'h77 ^ 8'h77 ^ 8'hA5);
    c0 = 1;

    // 40 push/pop pairs across the pointer wrap
    for (int k = 0; k < 40; k++) begin
      d0 = 8'h80 + 8'(k);
      sb.push_back(d0);
      tick();
      c0 = 0;
      exp_d = sb.pop_front();
      chk("wrap_odat", od0, exp_d);
      chk("wrap_lvl", lv0, 1);
    end
    i0 = 0;
    tick();
    exp_d = sb.pop_front();
    chk("wrap_last", od0, exp_d);
    o0 = 0;
    chk("wrap_empty", e0, 1);
    chk("wrap_udf", ud0, 0);

    // edge-strobe: one push per ien pulse
    i1 = 1;
    d1 = 8'h5A;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("edge_hold_lvl", lv1, 0);
    end
    i1 = 0;
    tick();
    chk("edge_push_lvl", lv1, 1);
    tick();
    tick();
    chk("edge_push_once", lv1, 1);
    o1 = 1;
    tick();
    chk("edge_pop_wait", lv1, 1);
    o1 = 0;
    tick();
    chk("edge_pop_odat", od1, 8'h5A);
    chk("edge_pop_lvl", lv1, 0);

    // ien falling across reset gives no push
    i1 = 1;
    d1 = 8'h66;
    tick();
    rst = 0;
    i1 = 0;
    tick();
    rst = 1;
    tick();
    tick();
    chk("edge_rst_lvl", lv1, 0);
    chk("edge_rst_ovf", ov1, 0);

    // fall-through read port
    chk("fwft_idle_odat", od2, 0);
    i2 = 1;
    d2 = 8'h3C;
    tick();
    chk("fwft_odat1", od2, 8'h3C);
    chk("fwft_nempty", e2, 0);
    d2 = 8'h3D;
    tick();
    i2 = 0;
    chk("fwft_head_keep", od2, 8'h3C);
    lvl = 2;
    chk("fwft_lvl", lv2, lvl);
    o2 = 1;
    tick();
    chk("fwft_next", od2, 8'h3D);
    tick();
    o2 = 0;
    chk("fwft_empty", e2, 1);
    chk("fwft_odat0", od2, 0);
    chk("fwft_udf", ud2, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
